multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle main controller that sequences the MIPS-style datapath (PC, register bank, ALU, data memory, and the regdst/alusrc/memtoreg/pcsrc muxes) one instruction phase per state. It decodes the latched opcode/funct and drives every datapath control line. It waits on a data-memory ready handshake with timeout and counts retired instructions. It sits beside `data_path` and replaces its externally driven control inputs.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in MEM waiting for mem_ready before abort (≥1).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  level enable: start and continue fetching.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  data-memory access complete.
- pc_write  out  1  PC load enable.
- ir_write  out  1  instruction register load enable.
- jump  out  1  PC source is the jump target.
- regwrite, regdst, pcsrc, memtoreg, mem_read, memwrite, alusrc  out  1 each  datapath controls.
- aluop  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- busy  out  1  state ≠ IDLE.
- illegal_instr  out  1  one-cycle pulse on an undecodable opcode or funct.
- mem_err  out  1  one-cycle pulse on MEM timeout.
- instr_count  out  CNT_W  retired instructions; wraps.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, op/funct latches=0, timeout counter=0, instr_count=0. All outputs are 0.
- Outputs are a combinational Moore decode of the state and the latched op/funct. The only exception is pc_write in BRANCH, which equals zero. Pulses are registered.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BRANCH=6, JUMP=7.
- IDLE: all controls 0. Go to FETCH when run=1.
- FETCH: ir_write=1, pc_write=1, pcsrc=0, aluop=add. Go to DECODE.
- DECODE: latch opcode and funct. Transition by opcode:
  - 000000 (R), 100011 (lw), 101011 (sw), 001000 (addi) → EXEC
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - anything else → illegal_instr pulse, go to FETCH (or IDLE if run=0), no retire.
  - R-type funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other funct is treated as illegal.
- EXEC:
  - R-type: alusrc=0, aluop from funct.
  - lw/sw/addi: alusrc=1, aluop=add.
  - R/addi → WB; lw/sw → MEM. Clear the timeout counter on entry.
- MEM:
  - lw holds mem_read=1; sw holds memwrite=1. alusrc=1, aluop=add held.
  - On mem_ready=1: lw → WB; sw → retire.
  - Otherwise the counter increments. When it reaches MEM_TIMEOUT-1 without ready: mem_err pulse, abort, no retire, no regwrite.
  - mem_ready on the timeout cycle counts as success.
- WB: regwrite=1.
  - R-type: regdst=1, memtoreg=0.
  - addi: regdst=0, memtoreg=0.
  - lw: regdst=0, memtoreg=1.
  - Then retire.
- BRANCH: alusrc=0, aluop=sub, pcsrc=1, pc_write=zero. Retire.
- JUMP: jump=1, pc_write=1. Retire.
- Retire: instr_count+1 (wraps at 2^CNT_W), then go to FETCH if run=1, else IDLE.
- run=0 mid-instruction: the instruction completes. The controller stops only at the FETCH boundary and never abandons a MEM access.
- rst low mid-MEM: mem_read and memwrite drop immediately (asynchronous). No write is committed by the controller.

Decomposition:
- Shared package `mips_ctrl_pkg`: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J), funct constants, ALUOP_* 3-bit codes, and the state encoding.
- Sub-module `alu_control`: combinational {op, funct, state} → aluop plus funct-illegal flag. It is reusable by a future pipelined decoder.

Test Plan:
- Reset and start: rst=0 then 1, run=0 → all outputs 0, state=0. Raise run → next cycle state=1 with ir_write=1, pc_write=1.
- R-type add (op 000000, funct 100000), run=1 → sequence FETCH, DECODE, EXEC (aluop=000, alusrc=0), WB (regwrite=1, regdst=1). instr_count 0→1 after 4 cycles.
- lw with mem_ready after 3 cycles → mem_read=1 for exactly 3 MEM cycles, then WB with memtoreg=1, regdst=0. Repeat as sw → memwrite only, no WB, count+1.
- sw with mem_ready never asserted, MEM_TIMEOUT=16 → 16 MEM cycles, mem_err pulse of 1 cycle, back to FETCH, count unchanged, regwrite never 1.
- beq with zero=1 then zero=0 → BRANCH: pcsrc=1, aluop=001, pc_write=1 then 0. j → JUMP with jump=1, pc_write=1. Count +1 for each.
- Opcode 111111, then funct 000111 under R-type → illegal_instr pulse, no retire. Also drop run during EXEC → instruction completes, then IDLE, busy=0. Count wrap check with CNT_W=4: 16 retires → instr_count=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// ALU operation codes, FSM state encoding and the datapath control bundle.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALUOP_ADD = 3'b000;
    localparam logic [2:0] ALUOP_SUB = 3'b001;
    localparam logic [2:0] ALUOP_AND = 3'b010;
    localparam logic [2:0] ALUOP_OR  = 3'b011;
    localparam logic [2:0] ALUOP_SLT = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_BRANCH = 3'd6,
        S_JUMP   = 3'd7
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ir_write;
        logic jump;
        logic regwrite;
        logic regdst;
        logic pcsrc;
        logic memtoreg;
        logic mem_read;
        logic memwrite;
        logic alusrc;
    } ctrl_t;

endpackage

// File: rtl/alu_control.sv
// Combinational ALU control: maps {op, funct, state} to the 3-bit aluop and
// flags R-type functs that the datapath cannot execute.
module alu_control
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  state_e     state,
    output logic [2:0] aluop,
    output logic       funct_illegal
);

    logic [2:0] fn_aluop;
    logic       fn_ok;

    always_comb begin
        fn_aluop = ALUOP_ADD;
        fn_ok    = 1'b1;
        case (funct)
            FN_ADD:  fn_aluop = ALUOP_ADD;
            FN_SUB:  fn_aluop = ALUOP_SUB;
            FN_AND:  fn_aluop = ALUOP_AND;
            FN_OR:   fn_aluop = ALUOP_OR;
            FN_SLT:  fn_aluop = ALUOP_SLT;
            default: fn_ok    = 1'b0;
        endcase
    end

    assign funct_illegal = (op == OP_RTYPE) && !fn_ok;

    always_comb begin
        aluop = ALUOP_ADD;
        case (state)
            S_EXEC:   aluop = (op == OP_RTYPE) ? fn_aluop : ALUOP_ADD;
            S_BRANCH: aluop = ALUOP_SUB;
            default:  aluop = ALUOP_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: one instruction phase per state, Moore
// decode of datapath controls, bounded data-memory wait, retire counter.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             jump,
    output logic             regwrite,
    output logic             regdst,
    output logic             pcsrc,
    output logic             memtoreg,
    output logic             mem_read,
    output logic             memwrite,
    output logic             alusrc,
    output logic [2:0]       aluop,
    output logic             busy,
    output logic             illegal_instr,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [5:0]       funct_q, funct_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;
    logic             retire;
    ctrl_t            ctrl;

    // In DECODE the incoming instruction is checked before it is latched.
    logic [5:0] op_sel, funct_sel;
    logic       funct_illegal;

    assign op_sel    = (state_q == S_DECODE) ? opcode : op_q;
    assign funct_sel = (state_q == S_DECODE) ? funct  : funct_q;

    alu_control u_alu_control (
        .op            (op_sel),
        .funct         (funct_sel),
        .state         (state_q),
        .aluop         (aluop),
        .funct_illegal (funct_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            funct_q   <= '0;
            tmo_q     <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        funct_d   = funct_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        mem_err_d = 1'b0;
        retire    = 1'b0;
        case (state_q)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                op_d    = opcode;
                funct_d = funct;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_illegal) begin
                            illegal_d = 1'b1;
                            state_d   = run ? S_FETCH : S_IDLE;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                    OP_LW, OP_SW, OP_ADDI: state_d = S_EXEC;
                    OP_BEQ:                state_d = S_BRANCH;
                    OP_J:                  state_d = S_JUMP;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = run ? S_FETCH : S_IDLE;
                    end
                endcase
            end
            S_EXEC: begin
                tmo_d   = '0;
                state_d = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // A ready seen on the last allowed cycle still wins over the abort.
                if (mem_ready) begin
                    if (op_q == OP_LW) state_d = S_WB;
                    else               retire  = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    mem_err_d = 1'b1;
                    state_d   = run ? S_FETCH : S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WB, S_BRANCH, S_JUMP: retire = 1'b1;
            default: state_d = S_IDLE;
        endcase
        if (retire) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            S_EXEC: ctrl.alusrc = (op_q != OP_RTYPE);
            S_MEM: begin
                ctrl.mem_read = (op_q == OP_LW);
                ctrl.memwrite = (op_q == OP_SW);
                ctrl.alusrc   = 1'b1;
            end
            S_WB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = (op_q == OP_RTYPE);
                ctrl.memtoreg = (op_q == OP_LW);
            end
            S_BRANCH: begin
                ctrl.pcsrc    = 1'b1;
                ctrl.pc_write = zero;
            end
            S_JUMP: begin
                ctrl.jump     = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign pc_write      = ctrl.pc_write;
    assign ir_write      = ctrl.ir_write;
    assign jump          = ctrl.jump;
    assign regwrite      = ctrl.regwrite;
    assign regdst        = ctrl.regdst;
    assign pcsrc         = ctrl.pcsrc;
    assign memtoreg      = ctrl.memtoreg;
    assign mem_read      = ctrl.mem_read;
    assign memwrite      = ctrl.memwrite;
    assign alusrc        = ctrl.alusrc;
    assign busy          = (state_q != S_IDLE);
    assign illegal_instr = illegal_q;
    assign mem_err       = mem_err_q;
    assign instr_count   = cnt_q;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus
// hand-written sequences for timeout, run drop, counter wrap and async reset.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready;
    logic       pc_write, ir_write, jump, regwrite, regdst, pcsrc, memtoreg;
    logic       mem_read, memwrite, alusrc, busy, illegal_instr, mem_err;
    logic [2:0] aluop, state;
    logic [3:0] instr_count;

    int n_chk = 0;
    int n_pass = 0;

    multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
        .ir_write(ir_write), .jump(jump), .regwrite(regwrite),
        .regdst(regdst), .pcsrc(pcsrc), .memtoreg(memtoreg),
        .mem_read(mem_read), .memwrite(memwrite), .alusrc(alusrc),
        .aluop(aluop), .busy(busy), .illegal_instr(illegal_instr),
        .mem_err(mem_err), .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] OPR = 6'b000000, OPLW = 6'b100011, OPSW = 6'b101011;
    localparam logic [5:0] OPAI = 6'b001000, OPBQ = 6'b000100, OPJ = 6'b000010;
    localparam logic [5:0] OPBAD = 6'b111111;
    localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FSLT = 6'b101010;
    localparam logic [5:0] FBAD = 6'b000111;

    // {pc_write, ir_write, jump, regwrite, regdst, pcsrc, memtoreg, mem_read, memwrite, alusrc}
    localparam logic [9:0] C_NONE = 10'b0000000000, C_FET = 10'b1100000000;
    localparam logic [9:0] C_EXI  = 10'b0000000001, C_WBR = 10'b0001100000;
    localparam logic [9:0] C_WBL  = 10'b0001001000, C_WBI = 10'b0001000000;
    localparam logic [9:0] C_MRD  = 10'b0000000101, C_MWR = 10'b0000000011;
    localparam logic [9:0] C_BRT  = 10'b1000010000, C_BRN = 10'b0000010000;
    localparam logic [9:0] C_JMP  = 10'b1010000000;

    typedef struct {
        logic [5:0] op, fn;
        logic       z, rdy;
        logic [2:0] st;
        logic [9:0] ctl;
        logic [2:0] alu;
        logic       ill, merr;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [9:0] ctl_now();
        return {pc_write, ir_write, jump, regwrite, regdst, pcsrc, memtoreg,
                mem_read, memwrite, alusrc};
    endfunction

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic rdy, input logic [2:0] st, input logic [9:0] ctl,
                       input logic [2:0] alu, input logic ill, input logic [3:0] cnt);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.ctl = ctl;
        v.alu = alu; v.ill = ill; v.merr = 1'b0; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit saw_rw;
        int n;
        logic [3:0] exp_cnt;

        rst = 1'b0; run = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        chk("reset_all", {state, ctl_now(), aluop, busy, illegal_instr, mem_err, instr_count},
            32'h0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("idle_run0", {state, ctl_now(), aluop, busy, illegal_instr, mem_err, instr_count},
            32'h0);

        // R add
        add(OPR, FADD, 0, 0, 3'd1, C_FET, 3'd0, 0, 4'd0);
        add(OPR, FADD, 0, 0, 3'd2, C_NONE, 3'd0, 0, 4'd0);
        add(OPR, FADD, 0, 0, 3'd3, C_NONE, 3'd0, 0, 4'd0);
        add(OPR, FADD, 0, 0, 3'd5, C_WBR, 3'd0, 0, 4'd0);
        add(OPR, FADD, 0, 0, 3'd1, C_FET, 3'd0, 0, 4'd1);
        // R sub
        add(OPR, FSUB, 0, 0, 3'd2, C_NONE, 3'd0, 0, 4'd1);
        add(OPR, FSUB, 0, 0, 3'd3, C_NONE, 3'd1, 0, 4'd1);
        add(OPR, FSUB, 0, 0, 3'd5, C_WBR, 3'd0, 0, 4'd1);
        add(OPR, FSUB, 0, 0, 3'd1, C_FET, 3'd0, 0, 4'd2);
        // lw, ready on the third MEM cycle
        add(OPLW, 6'd0, 0, 0, 3'd2, C_NONE, 3'd0, 0, 4'd2);
        add(OPLW, 6'd0, 0, 0, 3'd3, C_EXI, 3'd0, 0, 4'd2);
        add(OPLW, 6'd0, 0, 0, 3'd4, C_MRD, 3'd0, 0, 4'd2);
        add(OPLW, 6'd0, 0, 0, 3'd4, C_MRD, 3'd0, 0, 4'd2);
        add(OPLW, 6'd0, 0, 0, 3'd4, C_MRD, 3'd0, 0, 4'd2);
        add(OPLW, 6'd0, 0, 1, 3'd5, C_WBL, 3'd0, 0, 4'd2);
        add(OPLW, 6'd0, 0, 0, 3'd1, C_FET, 3'd0, 0, 4'd3);
        // sw, ready on the third MEM cycle
        add(OPSW, 6'd0, 0, 0, 3'd2, C_NONE, 3'd0, 0, 4'd3);
        add(OPSW, 6'd0, 0, 0, 3'd3, C_EXI, 3'd0, 0, 4'd3);
        add(OPSW, 6'd0, 0, 0, 3'd4, C_MWR, 3'd0, 0, 4'd3);
        add(OPSW, 6'd0, 0, 0, 3'd4, C_MWR, 3'd0, 0, 4'd3);
        add(OPSW, 6'd0, 0, 0, 3'd4, C_MWR, 3'd0, 0, 4'd3);
        add(OPSW, 6'd0, 0, 1, 3'd1, C_FET, 3'd0, 0, 4'd4);
        // beq taken / not taken
        add(OPBQ, 6'd0, 1, 0, 3'd2, C_NONE, 3'd0, 0, 4'd4);
        add(OPBQ, 6'd0, 1, 0, 3'd6, C_BRT, 3'd1, 0, 4'd4);
        add(OPBQ, 6'd0, 1, 0, 3'd1, C_FET, 3'd0, 0, 4'd5);
        add(OPBQ, 6'd0, 0, 0, 3'd2, C_NONE, 3'd0, 0, 4'd5);
        add(OPBQ, 6'd0, 0, 0, 3'd6, C_BRN, 3'd1, 0, 4'd5);
        add(OPBQ, 6'd0, 0, 0, 3'd1, C_FET, 3'd0, 0, 4'd6);
        // j
        add(OPJ, 6'd0, 0, 0, 3'd2, C_NONE, 3'd0, 0, 4'd6);
        add(OPJ, 6'd0, 0, 0, 3'd7, C_JMP, 3'd0, 0, 4'd6);
        add(OPJ, 6'd0, 0, 0, 3'd1, C_FET, 3'd0, 0, 4'd7);
        // illegal opcode, then illegal funct
        add(OPBAD, 6'd0, 0, 0, 3'd2, C_NONE, 3'd0, 0, 4'd7);
        add(OPBAD, 6'd0, 0, 0, 3'd1, C_FET, 3'd0, 1, 4'd7);
        add(OPR, FBAD, 0, 0, 3'd2, C_NONE, 3'd0, 0, 4'd7);
        add(OPR, FBAD, 0, 0, 3'd1, C_FET, 3'd0, 1, 4'd7);
        // addi
        add(OPAI, 6'd0, 0, 0, 3'd2, C_NONE, 3'd0, 0, 4'd7);
        add(OPAI, 6'd0, 0, 0, 3'd3, C_EXI, 3'd0, 0, 4'd7);
        add(OPAI, 6'd0, 0, 0, 3'd5, C_WBI, 3'd0, 0, 4'd7);
        add(OPAI, 6'd0, 0, 0, 3'd1, C_FET, 3'd0, 0, 4'd8);
        // R slt
        add(OPR, FSLT, 0, 0, 3'd2, C_NONE, 3'd0, 0, 4'd8);
        add(OPR, FSLT, 0, 0, 3'd3, C_NONE, 3'd4, 0, 4'd8);
        add(OPR, FSLT, 0, 0, 3'd5, C_WBR, 3'd0, 0, 4'd8);
        add(OPR, FSLT, 0, 0, 3'd1, C_FET, 3'd0, 0, 4'd9);

        run = 1'b1;
        foreach (tbl[i]) begin
            opcode = tbl[i].op; funct = tbl[i].fn; zero = tbl[i].z; mem_ready = tbl[i].rdy;
            step();
            chk($sformatf("vec[%0d]", i),
                {state, ctl_now(), aluop, busy, illegal_instr, mem_err, instr_count},
                {tbl[i].st, tbl[i].ctl, tbl[i].alu, tbl[i].st != 3'd0, tbl[i].ill,
                 tbl[i].merr, tbl[i].cnt});
        end

        // sw timeout: 16 MEM cycles, one-cycle mem_err, no retire
        opcode = OPSW; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        step();
        step();
        chk("tmo_exec", state, 3'd3);
        saw_rw = 1'b0;
        n = 0;
        step();
        while (state == 3'd4 && n < 40) begin
            if (regwrite || mem_err || !memwrite) saw_rw = 1'b1;
            n++;
            step();
        end
        chk("tmo_mem_cycles", n, 16);
        chk("tmo_clean_mem", saw_rw, 1'b0);
        chk("tmo_to_fetch", state, 3'd1);
        chk("tmo_err_pulse", mem_err, 1'b1);
        chk("tmo_no_retire", instr_count, 4'd9);
        step();
        chk("tmo_err_clear", mem_err, 1'b0);

        // run dropped during EXEC: instruction completes, then IDLE
        opcode = OPR; funct = FADD;
        step();
        chk("drop_exec", state, 3'd3);
        run = 1'b0;
        step();
        chk("drop_wb", {state, regwrite}, {3'd5, 1'b1});
        step();
        chk("drop_idle", {state, busy, instr_count}, {3'd0, 1'b0, 4'd10});
        step();
        chk("drop_stay", state, 3'd0);

        // 4-bit counter wrap over 16 jumps
        run = 1'b1; opcode = OPJ;
        step();
        exp_cnt = 4'd10;
        for (int i = 0; i < 16; i++) begin
            step();
            step();
            step();
            exp_cnt = exp_cnt + 4'd1;
            chk($sformatf("wrap[%0d]", i), {state, instr_count}, {3'd1, exp_cnt});
        end

        // async reset while lw is waiting in MEM
        opcode = OPLW; mem_ready = 1'b0;
        step();
        step();
        step();
        chk("mid_mem_read", {state, mem_read}, {3'd4, 1'b1});
        #2 rst = 1'b0;
        #1;
        chk("async_rst", {state, mem_read, memwrite, busy, instr_count}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
